// File: rtl/uart_text_ctrl_pkg.sv
// rtl/uart_text_ctrl_pkg.sv - character constants and FSM states shared by the UART text controller
// Contents:
//   CH_*           control/printable character codes decoded from the receive path
//   text_state_t   controller FSM states
//   is_printable   true for bytes that are written to the screen as-is
package uart_text_pkg;

  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_ESC      = 8'h1B;
  localparam logic [7:0] CH_BLANK    = 8'h20;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DECODE   = 3'd1,
    ST_WRITE    = 3'd2,
    ST_NEWLINE  = 3'd3,
    ST_CLR_LINE = 3'd4,
    ST_CLR_ALL  = 3'd5
  } text_state_t;

  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= CH_PRINT_LO) && (ch <= CH_PRINT_HI);
  endfunction

endpackage

// File: rtl/uart_text_ctrl_if.sv
// rtl/uart_text_ctrl_if.sv - flag-buffer handshake, character RAM write port and cursor status bundle
// Signals:
//   rx_flag, rx_data  flag buffer holds an unread byte / its data
//   clr_flag          one-cycle acknowledge that clears the flag buffer
//   wr_en, wr_addr, wr_data  character RAM write port
//   cur_col, cur_row  text cursor position
//   busy              controller is not idle
// Modports: slave = the controller, master = the flag buffer / RAM side environment.
interface uart_text_ctrl_if #(
  parameter int AW = 12
);
  logic          rx_flag;
  logic [7:0]    rx_data;
  logic          clr_flag;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [6:0]    cur_col;
  logic [4:0]    cur_row;
  logic          busy;

  modport slave (
    input  rx_flag, rx_data,
    output clr_flag, wr_en, wr_addr, wr_data, cur_col, cur_row, busy
  );

  modport master (
    output rx_flag, rx_data,
    input  clr_flag, wr_en, wr_addr, wr_data, cur_col, cur_row, busy
  );
endinterface

// File: rtl/uart_text_ctrl_text_cursor.sv
// rtl/uart_text_ctrl_text_cursor.sv - text cursor column/row/line-base counters
// Ports:
//   clk, reset        clock, synchronous active-high reset (cursor home)
//   i_inc, i_dec      step column forward / back
//   i_newline         column 0, next row (circular), line base stepped by COLS
//   i_home            column, row and line base to 0
//   o_col, o_row      cursor position
//   o_line_base       RAM address of column 0 on the cursor row
//   o_addr            RAM address under the cursor
//   o_col_first, o_col_last  column is 0 / COLS-1
module text_cursor #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int AW   = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_inc,
  input  logic          i_dec,
  input  logic          i_newline,
  input  logic          i_home,
  output logic [6:0]    o_col,
  output logic [4:0]    o_row,
  output logic [AW-1:0] o_line_base,
  output logic [AW-1:0] o_addr,
  output logic          o_col_first,
  output logic          o_col_last
);

  logic [6:0]    r_col;
  logic [4:0]    r_row;
  logic [AW-1:0] r_line_base;

  // line_base tracks row*COLS incrementally so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (reset || i_home) begin
      r_col       <= '0;
      r_row       <= '0;
      r_line_base <= '0;
    end else if (i_newline) begin
      r_col <= '0;
      if (r_row == 5'(ROWS - 1)) begin
        r_row       <= '0;
        r_line_base <= '0;
      end else begin
        r_row       <= r_row + 5'd1;
        r_line_base <= r_line_base + AW'(COLS);
      end
    end else if (i_inc) begin
      r_col <= r_col + 7'd1;
    end else if (i_dec) begin
      r_col <= r_col - 7'd1;
    end
  end

  assign o_col       = r_col;
  assign o_row       = r_row;
  assign o_line_base = r_line_base;
  assign o_addr      = r_line_base + AW'(r_col);
  assign o_col_first = (r_col == 7'd0);
  assign o_col_last  = (r_col == 7'(COLS - 1));

endmodule

// File: rtl/uart_text_ctrl.sv
// rtl/uart_text_ctrl.sv - UART receive sequencer driving the VGA character RAM and text cursor
// Ports:
//   clk    single system clock
//   reset  synchronous active-high reset; starts a full-screen clear
//   bus    uart_text_ctrl_if.slave: flag-buffer handshake in, character RAM write
//          port, cursor position and busy out (all outputs registered)
module uart_text_ctrl
  import uart_text_pkg::*;
#(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 30,
  parameter int         AW    = 12,
  parameter logic [7:0] BLANK = CH_BLANK
) (
  input  logic           clk,
  input  logic           reset,
  uart_text_ctrl_if.slave bus
);

  localparam int NCELLS = ROWS * COLS;
  // One extra bit so the clear counter can hold the terminal count.
  localparam int CW = AW + 1;

  text_state_t   r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [7:0]    r_byte, w_byte_n;
  logic          r_clr_flag, w_clr_flag_n;
  logic          r_wr_en, w_wr_en_n;
  logic [AW-1:0] r_wr_addr, w_wr_addr_n;
  logic [7:0]    r_wr_data, w_wr_data_n;
  logic          r_busy, w_busy_n;

  logic          w_inc, w_dec, w_newline, w_home;
  logic [6:0]    w_col;
  logic [4:0]    w_row;
  logic [AW-1:0] w_line_base, w_cur_addr;
  logic          w_col_first, w_col_last;

  text_cursor #(
    .COLS (COLS),
    .ROWS (ROWS),
    .AW   (AW)
  ) u_cursor (
    .clk         (clk),
    .reset       (reset),
    .i_inc       (w_inc),
    .i_dec       (w_dec),
    .i_newline   (w_newline),
    .i_home      (w_home),
    .o_col       (w_col),
    .o_row       (w_row),
    .o_line_base (w_line_base),
    .o_addr      (w_cur_addr),
    .o_col_first (w_col_first),
    .o_col_last  (w_col_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_CLR_ALL;
      r_cnt      <= '0;
      r_byte     <= '0;
      r_clr_flag <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= BLANK;
      r_busy     <= 1'b1;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_byte     <= w_byte_n;
      r_clr_flag <= w_clr_flag_n;
      r_wr_en    <= w_wr_en_n;
      r_wr_addr  <= w_wr_addr_n;
      r_wr_data  <= w_wr_data_n;
      r_busy     <= w_busy_n;
    end
  end

  // Output registers are loaded from the decision taken in the current state,
  // so a write is visible during the state that follows the decision (WRITE,
  // or the clear states while the counter is below its limit).
  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_byte_n     = r_byte;
    w_clr_flag_n = 1'b0;
    w_wr_en_n    = 1'b0;
    w_wr_addr_n  = r_wr_addr;
    w_wr_data_n  = r_wr_data;
    w_inc        = 1'b0;
    w_dec        = 1'b0;
    w_newline    = 1'b0;
    w_home       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.rx_flag) begin
          w_byte_n     = bus.rx_data;
          w_clr_flag_n = 1'b1;
          w_state_n    = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (is_printable(r_byte)) begin
          w_wr_en_n   = 1'b1;
          w_wr_addr_n = w_cur_addr;
          w_wr_data_n = r_byte;
          w_state_n   = ST_WRITE;
        end else if (r_byte == CH_CR) begin
          w_state_n = ST_NEWLINE;
        end else if (r_byte == CH_BS) begin
          if (!w_col_first) begin
            // Column steps back at this edge; the blank lands on the new position.
            w_dec       = 1'b1;
            w_wr_en_n   = 1'b1;
            w_wr_addr_n = w_cur_addr - AW'(1);
            w_wr_data_n = BLANK;
            w_state_n   = ST_WRITE;
          end else begin
            w_state_n = ST_IDLE;
          end
        end else if (r_byte == CH_ESC) begin
          w_cnt_n   = '0;
          w_state_n = ST_CLR_ALL;
        end else begin
          w_state_n = ST_IDLE;
        end
      end

      ST_WRITE: begin
        if (r_byte == CH_BS) begin
          w_state_n = ST_IDLE;
        end else if (w_col_last) begin
          w_state_n = ST_NEWLINE;
        end else begin
          w_inc     = 1'b1;
          w_state_n = ST_IDLE;
        end
      end

      ST_NEWLINE: begin
        w_newline = 1'b1;
        w_cnt_n   = '0;
        w_state_n = ST_CLR_LINE;
      end

      ST_CLR_LINE: begin
        if (r_cnt < CW'(COLS)) begin
          w_wr_en_n   = 1'b1;
          w_wr_addr_n = w_line_base + r_cnt[AW-1:0];
          w_wr_data_n = BLANK;
          w_cnt_n     = r_cnt + CW'(1);
        end else begin
          w_state_n = ST_IDLE;
        end
      end

      ST_CLR_ALL: begin
        if (r_cnt < CW'(NCELLS)) begin
          w_wr_en_n   = 1'b1;
          w_wr_addr_n = r_cnt[AW-1:0];
          w_wr_data_n = BLANK;
          w_cnt_n     = r_cnt + CW'(1);
        end else begin
          w_home    = 1'b1;
          w_state_n = ST_IDLE;
        end
      end

      default: begin
        // Unused encodings recover through a full clear.
        w_cnt_n   = '0;
        w_state_n = ST_CLR_ALL;
      end
    endcase

    w_busy_n = (w_state_n != ST_IDLE);
  end

  assign bus.clr_flag = r_clr_flag;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.cur_col  = w_col;
  assign bus.cur_row  = w_row;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_uart_text_ctrl.sv
// tb/tb_uart_text_ctrl.sv - self-checking bench for uart_text_ctrl against a screen-level model
module tb_uart_text_ctrl;
  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int AW     = 12;
  localparam int NCELLS = COLS * ROWS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_text_ctrl_if #(.AW(AW)) bus ();

  uart_text_ctrl #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .AW    (AW),
    .BLANK (8'h20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int last_wr_cyc = -1;
  int busy_fall_cyc = -1;
  int clr_cnt = 0;
  logic prev_busy = 1'b1;

  logic [19:0] obs_q[$];
  logic [19:0] exp_q[$];

  int m_col = 0;
  int m_row = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle; outputs are sampled at the falling edge and RAM writes recorded.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.wr_en === 1'b1) begin
      obs_q.push_back({bus.wr_addr, bus.wr_data});
      last_wr_cyc = cyc;
    end
    if (bus.clr_flag === 1'b1) clr_cnt++;
    if (prev_busy === 1'b1 && bus.busy === 1'b0) busy_fall_cyc = cyc;
    prev_busy = bus.busy;
  endtask

  // Screen model: cursor as (row, col), addresses as row*COLS+col.
  function automatic void m_push(input int addr, input logic [7:0] d);
    exp_q.push_back({AW'(addr), d});
  endfunction

  function automatic void m_newline();
    m_col = 0;
    m_row = (m_row + 1) % ROWS;
    for (int i = 0; i < COLS; i++) m_push(m_row * COLS + i, 8'h20);
  endfunction

  function automatic void m_clear_all();
    for (int i = 0; i < NCELLS; i++) m_push(i, 8'h20);
    m_col = 0;
    m_row = 0;
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      m_push(m_row * COLS + m_col, b);
      m_col++;
      if (m_col == COLS) m_newline();
    end else if (b == 8'h0D) begin
      m_newline();
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_push(m_row * COLS + m_col, 8'h20);
      end
    end else if (b == 8'h1B) begin
      m_clear_all();
    end
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 6000) begin
      tick();
      k++;
    end
    expect_eq("busy_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_writes(input string tag);
    int n;
    int f0;
    expect_eq({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n  = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    f0 = n_fail;
    for (int i = 0; i < n && (n_fail - f0) < 8; i++)
      expect_eq({tag, "_wr"}, 32'(obs_q[i]), 32'(exp_q[i]));
    expect_eq({tag, "_col"}, 32'(bus.cur_col), 32'(m_col));
    expect_eq({tag, "_row"}, 32'(bus.cur_row), 32'(m_row));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    tick();
    expect_eq("rst_busy", 32'(bus.busy), 32'd1);
    expect_eq("rst_wr_en", 32'(bus.wr_en), 32'd0);
    expect_eq("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    expect_eq("rst_wr_data", 32'(bus.wr_data), 32'h20);
    expect_eq("rst_clr_flag", 32'(bus.clr_flag), 32'd0);
    expect_eq("rst_col", 32'(bus.cur_col), 32'd0);
    expect_eq("rst_row", 32'(bus.cur_row), 32'd0);
    obs_q.delete();
    exp_q.delete();
    m_clear_all();
    reset = 1'b0;
    wait_idle();
    expect_eq("busy_fall", 32'(busy_fall_cyc), 32'(last_wr_cyc + 1));
    check_writes(tag);
  endtask

  // Presents a byte from idle and lets the controller finish with it.
  task automatic send_byte(input logic [7:0] b, input bit chk_lat);
    int k;
    int c0;
    c0 = clr_cnt;
    bus.rx_flag = 1'b1;
    bus.rx_data = b;
    k = 0;
    do begin
      tick();
      k++;
    end while (bus.clr_flag !== 1'b1 && k < 8);
    expect_eq("ack_latency", 32'(k), 32'd1);
    bus.rx_flag = 1'b0;
    m_byte(b);
    if (chk_lat) begin
      tick();
      expect_eq("lat_wr_en", 32'(bus.wr_en), 32'd1);
      expect_eq("lat_wr_data", 32'(bus.wr_data), 32'(b));
      expect_eq("lat_clr_low", 32'(bus.clr_flag), 32'd0);
      tick();
      expect_eq("lat_busy", 32'(bus.busy), 32'd0);
    end
    wait_idle();
    expect_eq("ack_once", 32'(clr_cnt - c0), 32'd1);
    check_writes("byte");
  endtask

  initial begin
    int k;
    int c0;
    int r;
    logic [7:0] b;

    bus.rx_flag = 1'b0;
    bus.rx_data = 8'h00;

    do_reset("power_clear");

    send_byte(8'h41, 1'b1);

    send_byte(8'h1B, 1'b0);
    for (int i = 0; i < COLS; i++) send_byte(8'h61, 1'b0);
    expect_eq("wrap_row", 32'(bus.cur_row), 32'd1);
    expect_eq("wrap_col", 32'(bus.cur_col), 32'd0);

    send_byte(8'h1B, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    send_byte(8'h08, 1'b0);
    expect_eq("bs_col", 32'(bus.cur_col), 32'd1);
    send_byte(8'h08, 1'b0);
    send_byte(8'h08, 1'b0);
    expect_eq("bs_col0", 32'(bus.cur_col), 32'd0);

    while (m_row != ROWS - 1) send_byte(8'h0D, 1'b0);
    send_byte(8'h0D, 1'b0);
    expect_eq("cr_wrap_row", 32'(bus.cur_row), 32'd0);

    // ESC clear with a new byte waiting part-way through it.
    c0 = clr_cnt;
    bus.rx_flag = 1'b1;
    bus.rx_data = 8'h1B;
    tick();
    bus.rx_flag = 1'b0;
    m_byte(8'h1B);
    repeat (200) tick();
    bus.rx_flag = 1'b1;
    bus.rx_data = 8'h5A;
    k = 0;
    while (bus.clr_flag !== 1'b1 && k < 4000) begin
      tick();
      k++;
    end
    expect_eq("midclr_ack_seen", 32'(bus.clr_flag), 32'd1);
    expect_eq("midclr_writes_before_ack", 32'(obs_q.size()), 32'(NCELLS));
    expect_eq("midclr_ack_count", 32'(clr_cnt - c0), 32'd2);
    bus.rx_flag = 1'b0;
    m_byte(8'h5A);
    wait_idle();
    check_writes("esc_then_5a");

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      b = 8'($urandom_range(32'h20, 32'h7E));
      else if (r < 72) b = 8'h0D;
      else if (r < 82) b = 8'h08;
      else if (r < 87) b = 8'h0A;
      else if (r < 98) b = 8'($urandom_range(0, 255));
      else             b = 8'h1B;
      send_byte(b, 1'b0);
    end

    // Reset in the middle of an ESC clear restarts the clear from address 0.
    bus.rx_flag = 1'b1;
    bus.rx_data = 8'h1B;
    tick();
    bus.rx_flag = 1'b0;
    repeat (700) tick();
    do_reset("reset_mid_clear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_text_ctrl.md
Name: uart_text_ctrl

Overview:
- Sequences the UART receive path for the keyboard-to-monitor design.
- Consumes bytes from the receiver's flag buffer through its flag/clear handshake and decodes control characters.
- Drives a single-port character RAM that the VGA text renderer reads, and maintains the text cursor.
- Clears the whole screen after reset and on ESC. Clears each new line on newline or wrap.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows per screen; row index wraps circularly
- AW, 12, character RAM address width; ROWS*COLS must be <= 2^AW
- BLANK, 8'h20, fill character used by all clear operations

Ports:
- clk  in  1  system clock; the single clock of the block
- reset  in  1  synchronous, active-high reset
- rx_flag  in  1  flag buffer holds an unread byte
- rx_data  in  8  flag buffer data; valid while rx_flag=1
- clr_flag  out  1  one-cycle pulse that acknowledges the byte and clears the flag buffer
- wr_en  out  1  character RAM write strobe
- wr_addr  out  AW  character RAM address = row*COLS + col
- wr_data  out  8  character RAM write data
- cur_col  out  7  cursor column, 0..COLS-1
- cur_row  out  5  cursor row, 0..ROWS-1
- busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered.
- Reset values: wr_en=0, wr_addr=0, wr_data=BLANK, clr_flag=0, cur_col=0, cur_row=0, busy=1. The state goes to CLR_ALL with the clear counter at 0.
- Reset asserted at any point, including mid-clear, restarts CLR_ALL from address 0.
- CLR_ALL:
  - One write per cycle, data=BLANK, addresses 0..ROWS*COLS-1 ascending.
  - After the last write: cursor and line base are set to 0, then go to IDLE.
- IDLE (busy=0):
  - When rx_flag=1 is sampled, latch rx_data, assert clr_flag on the next cycle for exactly 1 cycle, and go to DECODE.
  - rx_flag is ignored in every other state. The byte stays held in the flag buffer until the FSM returns to IDLE.
- DECODE: classify the latched byte.
  - Printable 8'h20..8'h7E: go to WRITE.
  - 8'h0D (CR): go to NEWLINE.
  - 8'h0A (LF): ignored, go to IDLE.
  - 8'h08 (BS), col>0: col <= col-1, then go to WRITE with data BLANK at the new position.
  - 8'h08 (BS), col==0: no write, no row reversal, go to IDLE.
  - 8'h1B (ESC): go to CLR_ALL, cursor home afterwards.
  - Any other byte: ignored, go to IDLE.
- WRITE:
  - wr_en=1 for one cycle at line_base+col.
  - For a printable byte: if col==COLS-1, go to NEWLINE; otherwise col <= col+1 and go to IDLE.
  - For BS: go to IDLE with no advance.
- NEWLINE:
  - col <= 0.
  - row <= (row==ROWS-1) ? 0 : row+1.
  - line_base <= (row==ROWS-1) ? 0 : line_base+COLS.
  - Go to CLR_LINE.
- CLR_LINE: COLS consecutive BLANK writes at line_base..line_base+COLS-1, then go to IDLE.
- Latency:
  - rx_flag sampled high at cycle n: clr_flag=1 at n+1 (DECODE), wr_en=1 at n+2 for a printable byte, busy=0 again at n+3.
  - clr_flag therefore clears the flag buffer before IDLE can sample rx_flag again, so no double consumption.
- Address arithmetic: no multiplier. line_base is an AW-bit register stepped by COLS, and wr_addr = line_base + col zero-extended to AW bits.
- Busy windows:
  - Worst case is CLR_ALL at ROWS*COLS cycles (2400), which is well below one byte time at the configured baud rate.
  - A byte arriving during any busy window is therefore never lost.

Decomposition:
- Shared package uart_text_pkg:
  - Character constants: CH_CR=8'h0D, CH_LF=8'h0A, CH_BS=8'h08, CH_ESC=8'h1B, BLANK, and the printable range bounds.
  - FSM state encoding: IDLE, DECODE, WRITE, NEWLINE, CLR_LINE, CLR_ALL.
- One sub-module, text_cursor:
  - Holds col, row and line_base, with increment, decrement, newline-wrap and home controls.
  - Produces the cursor address combinationally from the registered counters.
  - The FSM and the clear counter stay in uart_text_ctrl.

Test Plan:
- Reset pulse: exactly 2400 consecutive writes of 8'h20, addresses 0..2399. busy falls the cycle after address 2399. cursor=(0,0).
- rx_data=8'h41 with rx_flag at cycle n after clear: clr_flag high only at n+1. Write of 8'h41 at addr 0 at n+2. cur_col=1. One byte, one write.
- 80 bytes 8'h61: last write at addr 79, then 80 BLANK writes at 80..159. cursor=(row1, col0).
- Send "AB" then BS: BLANK written at addr 1, cur_col=1. BS at col 0 produces no write and no cursor change.
- Cursor on row 29, send CR: row wraps to 0, BLANK writes at 0..79, cursor=(0,0).
- ESC after text, with rx_flag=1 (data 8'h5A) raised mid-clear: full 2400-write clear, no clr_flag until IDLE. Then 8'h5A written at addr 0.
- Reset asserted mid-clear: clear restarts at addr 0.
